sevenseg_scan_decoder: RTL

SEVENSEG_SCAN_DECODER -- requirements
Module: sevenseg_scan_decoder

---
 rtl/sevenseg_scan_decoder_pkg.sv | 26 ++
 rtl/seg7_to_hex.sv | 21 ++
 rtl/sevenseg_scan_decoder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_decoder_pkg.sv
// rtl/sevenseg_scan_decoder_pkg.sv - shared font, segment order and state encoding
package sevenseg_scan_decoder_pkg;

  // Segment bit positions within the active-low a..g pattern
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] FONT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUBLISH = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// rtl/seg7_to_hex.sv - active-low seven-segment pattern to hex nibble
module seg7_to_hex
  import sevenseg_scan_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b0;
    nibble = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == FONT[i]) begin
        valid  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// rtl/sevenseg_scan_decoder.sv - recovers hex digits from a multiplexed 7-segment scan
module sevenseg_scan_decoder
  import sevenseg_scan_decoder_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  AtoG,
  input  logic [7:0]  anode,
  input  logic        DP,
  input  logic        err_clr,
  output logic [31:0] digits,
  output logic [7:0]  dp_bits,
  output logic        frame_valid,
  output logic        seg_error,
  output logic        scan_error,
  output logic        timeout
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE);
  localparam logic [TW-1:0] IDLE_MAX    = TW'(TIMEOUT);

  logic [15:0]   sync1, sync2, prev;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    mask, mask_d;
  logic [31:0]   slot_nib;
  logic [7:0]    slot_dp;
  scan_state_e   state, state_d;

  logic [7:0] s_anode, sel;
  logic [6:0] s_seg;
  logic       s_dp;
  logic       changed, sample, one_hot, capture, multi, timeout_hit;
  logic [2:0] cap_idx;
  logic       font_ok;
  logic [3:0] font_nib;

  // {anode, AtoG, DP} synchronized together; idle bus is all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= {anode, AtoG, DP};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign s_anode = sync2[15:8];
  assign s_seg   = sync2[7:1];
  assign s_dp    = sync2[0];
  assign sel     = ~s_anode;
  assign changed = (sync2 != prev);
  assign sample  = !changed && (settle_cnt == SETTLE_LAST);

  seg7_to_hex u_seg7_to_hex (
    .pattern (s_seg),
    .valid   (font_ok),
    .nibble  (font_nib)
  );

  always_comb begin
    one_hot = (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
    cap_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) cap_idx = 3'(i);
    end
    capture     = sample && one_hot;
    multi       = sample && (sel != 8'd0) && !one_hot;
    timeout_hit = (idle_cnt == IDLE_MAX) && (mask != 8'd0) &&
                  (state != ST_PUBLISH) && !capture;

    // Publish clears first so a same-cycle capture lands in the fresh mask
    mask_d = mask;
    if (state == ST_PUBLISH || timeout_hit) mask_d = 8'd0;
    if (capture) mask_d[cap_idx] = 1'b1;

    state_d = state;
    case (state)
      ST_PUBLISH: state_d = ST_IDLE;
      default: begin
        if (mask_d == 8'hFF)     state_d = ST_PUBLISH;
        else if (mask_d != 8'd0) state_d = ST_COLLECT;
        else                     state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt  <= '0;
      idle_cnt    <= '0;
      mask        <= 8'd0;
      slot_nib    <= 32'd0;
      slot_dp     <= 8'd0;
      digits      <= 32'd0;
      dp_bits     <= 8'd0;
      frame_valid <= 1'b0;
      timeout     <= 1'b0;
      seg_error   <= 1'b0;
      scan_error  <= 1'b0;
    end else begin
      if (changed)                      settle_cnt <= '0;
      else if (settle_cnt != SETTLE_MAX) settle_cnt <= settle_cnt + 1'b1;

      if (capture || timeout_hit)   idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;

      mask        <= mask_d;
      frame_valid <= (state == ST_PUBLISH);
      timeout     <= timeout_hit;

      if (capture) begin
        slot_nib[cap_idx*4 +: 4] <= font_ok ? font_nib : 4'd0;
        slot_dp[cap_idx]         <= ~s_dp;
      end

      if (state == ST_PUBLISH) begin
        digits  <= slot_nib;
        dp_bits <= slot_dp;
      end

      if (capture && !font_ok) seg_error <= 1'b1;
      else if (err_clr)        seg_error <= 1'b0;

      if (multi)        scan_error <= 1'b1;
      else if (err_clr) scan_error <= 1'b0;
    end
  end

endmodule
